face_dbg_probe_tap: RTL and testbench



---
 rtl/face_dbg_probe_tap.sv | 183 ++++++++++++++++++
 tb/tb_face_dbg_probe_tap.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/face_dbg_probe_tap.sv
// face_dbg_probe_tap: raster tracker plus frame-synchronous face-box commit onto the LA probe bus.
// Latency: probes update 1 cycle after vs/de are sampled; res_ready is combinational (~shadow_full | vs_rise).
// Backpressure: one-deep shadow, res_ready low while full until next frame start. FACE_DBG_ORDER_EN orders/clamps box at commit.
module face_dbg_probe_tap #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int CW          = 10,
    parameter int MAX_BOX_AGE = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vid_vs,
    input  logic          vid_de,
    input  logic          res_valid,
    output logic          res_ready,
    input  logic [CW-1:0] res_x0,
    input  logic [CW-1:0] res_y0,
    input  logic [CW-1:0] res_x1,
    input  logic [CW-1:0] res_y1,
    output logic [3:0]    probe0,
    output logic [CW-1:0] probe1,
    output logic [CW-1:0] probe2,
    output logic [CW-1:0] probe3,
    output logic [CW-1:0] probe4,
    output logic [CW-1:0] probe5,
    output logic [CW-1:0] probe6
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SYNC  = 2'b01,
        ST_TRACK = 2'b10,
        ST_STALE = 2'b11
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [3:0]    AGE_MAX = 4'(MAX_BOX_AGE);

    // Age is a 4-bit field and the box limits must fit the coordinate width.
    if (MAX_BOX_AGE < 1 || MAX_BOX_AGE > 15 ||
        H_ACTIVE > (1 << CW) || V_ACTIVE > (1 << CW)) begin : g_param_check
        $error("face_dbg_probe_tap: parameter out of range");
    end

    logic          r_vs_q;
    logic          r_de_q;
    logic [CW-1:0] r_hcnt;
    logic [CW-1:0] r_vcnt;
    state_t        r_state;
    logic          r_toggle;
    logic [3:0]    r_age;
    logic          r_shadow_full;
    logic [CW-1:0] r_sh_x0, r_sh_y0, r_sh_x1, r_sh_y1;
    logic [CW-1:0] r_box_x0, r_box_y0, r_box_x1, r_box_y1;

    logic          w_vs_rise;
    logic          w_de_fall;
    logic          w_accept;
    logic [3:0]    w_age_inc;
    state_t        w_state_nxt;
    logic [CW-1:0] w_cx0, w_cy0, w_cx1, w_cy1;

    assign w_vs_rise = vid_vs & ~r_vs_q;
    assign w_de_fall = ~vid_de & r_de_q;
    assign res_ready = ~r_shadow_full | w_vs_rise;
    assign w_accept  = res_valid & res_ready;
    assign w_age_inc = (r_age >= AGE_MAX) ? AGE_MAX : r_age + 4'd1;

`ifdef FACE_DBG_ORDER_EN
    localparam logic [CW-1:0] X_LIM = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_LIM = CW'(V_ACTIVE - 1);

    logic [CW-1:0] w_xl, w_xh, w_yl, w_yh;

    always_comb begin
        w_xl  = (r_sh_x0 > r_sh_x1) ? r_sh_x1 : r_sh_x0;
        w_xh  = (r_sh_x0 > r_sh_x1) ? r_sh_x0 : r_sh_x1;
        w_yl  = (r_sh_y0 > r_sh_y1) ? r_sh_y1 : r_sh_y0;
        w_yh  = (r_sh_y0 > r_sh_y1) ? r_sh_y0 : r_sh_y1;
        w_cx0 = (w_xl > X_LIM) ? X_LIM : w_xl;
        w_cx1 = (w_xh > X_LIM) ? X_LIM : w_xh;
        w_cy0 = (w_yl > Y_LIM) ? Y_LIM : w_yl;
        w_cy1 = (w_yh > Y_LIM) ? Y_LIM : w_yh;
    end
`else
    assign w_cx0 = r_sh_x0;
    assign w_cy0 = r_sh_y0;
    assign w_cx1 = r_sh_x1;
    assign w_cy1 = r_sh_y1;
`endif

    // State only moves at frame start; a pending shadow at that moment is a commit.
    always_comb begin
        w_state_nxt = r_state;
        if (w_vs_rise) begin
            case (r_state)
                ST_IDLE:  w_state_nxt = r_shadow_full ? ST_TRACK : ST_SYNC;
                ST_SYNC:  if (r_shadow_full) w_state_nxt = ST_TRACK;
                ST_TRACK: if (!r_shadow_full && w_age_inc == AGE_MAX) w_state_nxt = ST_STALE;
                ST_STALE: if (r_shadow_full) w_state_nxt = ST_TRACK;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_q <= 1'b0;
            r_de_q <= 1'b0;
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            r_vs_q <= vid_vs;
            r_de_q <= vid_de;
            if (vid_de) begin
                r_hcnt <= (r_hcnt == CNT_MAX) ? r_hcnt : r_hcnt + 1'b1;
            end else if (w_de_fall) begin
                r_hcnt <= '0;
            end
            if (w_vs_rise) begin
                r_vcnt <= '0;
            end else if (w_de_fall) begin
                r_vcnt <= (r_vcnt == CNT_MAX) ? r_vcnt : r_vcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_toggle <= 1'b0;
            r_age    <= 4'd0;
            r_box_x0 <= '0;
            r_box_y0 <= '0;
            r_box_x1 <= '0;
            r_box_y1 <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_vs_rise) begin
                r_toggle <= ~r_toggle;
                if (r_shadow_full) begin
                    r_box_x0 <= w_cx0;
                    r_box_y0 <= w_cy0;
                    r_box_x1 <= w_cx1;
                    r_box_y1 <= w_cy1;
                    r_age    <= 4'd0;
                end else begin
                    r_age <= w_age_inc;
                end
            end
        end
    end

    // A result accepted on the commit cycle refills the shadow just vacated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_full <= 1'b0;
            r_sh_x0       <= '0;
            r_sh_y0       <= '0;
            r_sh_x1       <= '0;
            r_sh_y1       <= '0;
        end else begin
            if (w_accept) begin
                r_shadow_full <= 1'b1;
                r_sh_x0       <= res_x0;
                r_sh_y0       <= res_y0;
                r_sh_x1       <= res_x1;
                r_sh_y1       <= res_y1;
            end else if (w_vs_rise) begin
                r_shadow_full <= 1'b0;
            end
        end
    end

    assign probe0 = {r_state, r_shadow_full, r_toggle};
    assign probe1 = r_hcnt;
    assign probe2 = r_vcnt;
    assign probe3 = r_box_x0;
    assign probe4 = r_box_y0;
    assign probe5 = r_box_x1;
    assign probe6 = r_box_y1;

endmodule

// File: tb/tb_face_dbg_probe_tap.sv
// Bench for face_dbg_probe_tap: frame-level reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_face_dbg_probe_tap;
    localparam int CW     = 10;
    localparam int HA     = 640;
    localparam int VA     = 480;
    localparam int MAXAGE = 15;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vid_vs = 1'b0;
    logic          vid_de = 1'b0;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [CW-1:0] res_x0 = '0, res_y0 = '0, res_x1 = '0, res_y1 = '0;
    logic [3:0]    probe0;
    logic [CW-1:0] probe1, probe2, probe3, probe4, probe5, probe6;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    face_dbg_probe_tap #(.H_ACTIVE(HA), .V_ACTIVE(VA), .CW(CW), .MAX_BOX_AGE(MAXAGE)) dut (
        .clk(clk), .rst_n(rst_n), .vid_vs(vid_vs), .vid_de(vid_de),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_x0(res_x0), .res_y0(res_y0), .res_x1(res_x1), .res_y1(res_y1),
        .probe0(probe0), .probe1(probe1), .probe2(probe2), .probe3(probe3),
        .probe4(probe4), .probe5(probe5), .probe6(probe6)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: frame-level view (started / box ever seen / frames since box).
    int m_h, m_v, m_age;
    bit m_vsq, m_deq, m_tog, m_started, m_have, m_full;
    int m_sh[4];
    int m_box[4];
    bit mv_rise, mv_fall, mv_rdy;

    function automatic int m_state();
        if (!m_started)       return 0;
        if (!m_have)          return 1;
        if (m_age >= MAXAGE)  return 3;
        return 2;
    endfunction

    function automatic void do_commit();
`ifdef FACE_DBG_ORDER_EN
        int xl, xh, yl, yh;
        xl = (m_sh[0] < m_sh[2]) ? m_sh[0] : m_sh[2];
        xh = (m_sh[0] < m_sh[2]) ? m_sh[2] : m_sh[0];
        yl = (m_sh[1] < m_sh[3]) ? m_sh[1] : m_sh[3];
        yh = (m_sh[1] < m_sh[3]) ? m_sh[3] : m_sh[1];
        m_box[0] = (xl > HA - 1) ? HA - 1 : xl;
        m_box[1] = (yl > VA - 1) ? VA - 1 : yl;
        m_box[2] = (xh > HA - 1) ? HA - 1 : xh;
        m_box[3] = (yh > VA - 1) ? VA - 1 : yh;
`else
        for (int i = 0; i < 4; i++) m_box[i] = m_sh[i];
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h = 0; m_v = 0; m_age = 0;
            m_vsq = 0; m_deq = 0; m_tog = 0; m_started = 0; m_have = 0; m_full = 0;
            for (int i = 0; i < 4; i++) begin
                m_sh[i] = 0;
                m_box[i] = 0;
            end
        end else begin
            mv_rise = vid_vs && !m_vsq;
            mv_fall = !vid_de && m_deq;
            mv_rdy  = !m_full || mv_rise;
            if (mv_rise) begin
                m_tog = !m_tog;
                m_started = 1;
                if (m_full) begin
                    do_commit();
                    m_have = 1;
                    m_age = 0;
                end else begin
                    m_age = (m_age + 1 > MAXAGE) ? MAXAGE : m_age + 1;
                end
            end
            if (vid_de) m_h = (m_h < CMAX) ? m_h + 1 : CMAX;
            else if (mv_fall) m_h = 0;
            if (mv_rise) m_v = 0;
            else if (mv_fall) m_v = (m_v < CMAX) ? m_v + 1 : CMAX;
            if (res_valid && mv_rdy) begin
                m_sh[0] = res_x0; m_sh[1] = res_y0; m_sh[2] = res_x1; m_sh[3] = res_y1;
                m_full = 1;
            end else if (mv_rise) begin
                m_full = 0;
            end
            m_vsq = vid_vs;
            m_deq = vid_de;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_probe0", probe0, m_state() * 4 + (m_full ? 2 : 0) + (m_tog ? 1 : 0));
            chk("cyc_hcnt", probe1, m_h);
            chk("cyc_vcnt", probe2, m_v);
            chk("cyc_x0", probe3, m_box[0]);
            chk("cyc_y0", probe4, m_box[1]);
            chk("cyc_x1", probe5, m_box[2]);
            chk("cyc_y1", probe6, m_box[3]);
            chk("cyc_ready", res_ready, (!m_full || (vid_vs && !m_vsq)) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        vid_vs = 1'b1;
        tick();
        tick();
        vid_vs = 1'b0;
        tick();
    endtask

    task automatic send_result(input int x0, input int y0, input int x1, input int y1);
        res_x0 = CW'(x0); res_y0 = CW'(y0); res_x1 = CW'(x1); res_y1 = CW'(y1);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        cmp_en = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        // Load a box, then reset in the middle of an active line with a shadow pending.
        send_result(1, 2, 3, 4);
        vs_pulse();
        send_result(5, 6, 7, 8);
        vid_de = 1'b1;
        repeat (100) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_probe0", probe0, 0);
        chk("rst_hcnt", probe1, 0);
        chk("rst_x0", probe3, 0);
        chk("rst_ready", res_ready, 1);
        vid_de = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Three full lines, then frame start with nothing pending.
        for (int l = 0; l < 3; l++) begin
            vid_de = 1'b1;
            repeat (HA) tick();
            vid_de = 1'b0;
            repeat (10) tick();
        end
        @(negedge clk);
        chk("vcnt_3lines", probe2, 3);
        vs_pulse();
        @(negedge clk);
        chk("sync_probe0", probe0, 4'b0101);
        chk("vcnt_cleared", probe2, 0);

        // Mid-frame result; ready drops after accept; committed at next frame start.
        vid_de = 1'b1;
        repeat (50) tick();
        send_result(10, 20, 100, 200);
        @(negedge clk);
        chk("ready_after_accept", res_ready, 0);
        repeat (50) tick();
        vid_de = 1'b0;
        repeat (5) tick();
        vs_pulse();
        @(negedge clk);
        chk("t3_x0", probe3, 10);
        chk("t3_y0", probe4, 20);
        chk("t3_x1", probe5, 100);
        chk("t3_y1", probe6, 200);
        chk("t3_state", probe0[3:2], 2);
        chk("t3_ready", res_ready, 1);

        // Second result held while the shadow is full; taken on the vs_rise cycle.
        send_result(11, 22, 33, 44);
        res_x0 = 10'd55; res_y0 = 10'd66; res_x1 = 10'd77; res_y1 = 10'd88;
        res_valid = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("t4_ready_blocked", res_ready, 0);
        tick();
        vid_vs = 1'b1;
        @(negedge clk);
        chk("t4_ready_vsrise", res_ready, 1);
        tick();
        res_valid = 1'b0;
        tick();
        vid_vs = 1'b0;
        tick();
        @(negedge clk);
        chk("t4_old_x0", probe3, 11);
        chk("t4_old_y1", probe6, 44);
        chk("t4_full", probe0[1], 1);
        vs_pulse();
        @(negedge clk);
        chk("t4_new_x0", probe3, 55);
        chk("t4_new_y1", probe6, 88);
        chk("t4_empty", probe0[1], 0);

        // Ageing to STALE, box kept, then recovery.
        repeat (MAXAGE - 1) vs_pulse();
        @(negedge clk);
        chk("t5_track_14", probe0[3:2], 2);
        vs_pulse();
        @(negedge clk);
        chk("t5_stale_15", probe0[3:2], 3);
        chk("t5_box_kept", probe5, 77);
        send_result(1, 2, 3, 4);
        vs_pulse();
        @(negedge clk);
        chk("t5_back_track", probe0[3:2], 2);
        chk("t5_new_box", probe3, 1);

        // Unordered, out-of-range box.
        send_result(100, 200, 700, 20);
        vs_pulse();
        @(negedge clk);
`ifdef FACE_DBG_ORDER_EN
        chk("t6_x0", probe3, 100);
        chk("t6_y0", probe4, 20);
        chk("t6_x1", probe5, 639);
        chk("t6_y1", probe6, 200);
`else
        chk("t6_x0", probe3, 100);
        chk("t6_y0", probe4, 200);
        chk("t6_x1", probe5, 700);
        chk("t6_y1", probe6, 20);
`endif

        repeat (5) tick();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
